bcd_seg_scan: RTL and testbench

Multiplexed 7-segment display driver sitting directly downstream of the binary-to-BCD converter in the ThreeColorLight design. Takes the converter's 25-bit packed BCD word (six full digits plus a 1-bit millions digit), latches it once per scan frame to avoid tearing, and time-multiplexes seven common-anode digits with optional leading-zero blanking. Outputs are fully registered and drive the board pins directly.

---
 rtl/bcd_seg_scan.sv | 148 ++++++++++++++
 tb/tb_bcd_seg_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
// Seven-digit multiplexed common-anode 7-segment driver fed by a packed BCD word.
// The frame is latched once per scan cycle so a changing source never tears the display.
module bcd_seg_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        Sys_CLK,
    input  logic        Sys_RST_N,
    input  logic [24:0] Data_BCD,
    input  logic        Blank_En,
    output logic [7:0]  Seg_Out,
    output logic [6:0]  Dig_Sel,
    output logic        Frame_Done
);

    localparam logic [15:0] PRE_LAST   = 16'(SCAN_DIV - 32'd1);
    localparam logic [15:0] PRE_PENULT = 16'(SCAN_DIV - 32'd2);
    localparam logic [2:0]  IDX_LAST   = 3'd6;

    logic [15:0] pre_q, pre_d;
    logic [2:0]  idx_q, idx_d;
    logic [24:0] frm_q, frm_d;
    logic        blk_q, blk_d;
    logic        load_pending_q, load_pending_d;
    logic [7:0]  seg_q, seg_d;
    logic [6:0]  dig_q, dig_d;
    logic        frame_done_q, frame_done_d;
    logic [6:0]  blank_s;
    logic [3:0]  cur_digit_s;

    function automatic logic [3:0] digit_val(input logic [24:0] f, input logic [2:0] i);
        case (i)
            3'd0:    digit_val = f[3:0];
            3'd1:    digit_val = f[7:4];
            3'd2:    digit_val = f[11:8];
            3'd3:    digit_val = f[15:12];
            3'd4:    digit_val = f[19:16];
            3'd5:    digit_val = f[23:20];
            3'd6:    digit_val = {3'b000, f[24]};
            default: digit_val = 4'd0;
        endcase
    endfunction

    // A digit is blank when it and everything above it is zero; a non-BCD nibble counts as non-zero.
    function automatic logic [6:0] blank_mask(input logic [24:0] f, input logic b);
        logic zero_above;
        blank_mask = 7'b000_0000;
        zero_above = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            zero_above = zero_above & (digit_val(f, 3'(i)) == 4'd0);
            if (b && (i != 0) && zero_above) begin
                blank_mask[i] = 1'b1;
            end else begin
                blank_mask[i] = 1'b0;
            end
        end
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hBF;
        endcase
    endfunction

    // Scan counters and frame latch; the scan holds still during the post-reset load cycle.
    always_comb begin
        pre_d          = pre_q;
        idx_d          = idx_q;
        frm_d          = frm_q;
        blk_d          = blk_q;
        load_pending_d = load_pending_q;
        if (load_pending_q) begin
            frm_d          = Data_BCD;
            blk_d          = Blank_En;
            load_pending_d = 1'b0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = 16'd0;
            if (idx_q == IDX_LAST) begin
                idx_d = 3'd0;
                frm_d = Data_BCD;
                blk_d = Blank_En;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            pre_d = pre_q + 16'd1;
        end
    end

    // Pin decode of the current state; Frame_Done looks one cycle ahead so it lands in the wrap cycle.
    always_comb begin
        blank_s      = blank_mask(frm_q, blk_q);
        cur_digit_s  = digit_val(frm_q, idx_q);
        seg_d        = 8'hFF;
        dig_d        = 7'h7F;
        frame_done_d = 1'b0;
        if (load_pending_q) begin
            seg_d        = 8'hFF;
            dig_d        = 7'h7F;
            frame_done_d = 1'b0;
        end else begin
            dig_d = ~(7'b000_0001 << idx_q);
            if (blank_s[idx_q]) begin
                seg_d = 8'hFF;
            end else begin
                seg_d = seg_decode(cur_digit_s);
            end
            frame_done_d = (idx_q == IDX_LAST) && (pre_q == PRE_PENULT);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Sys_CLK) begin
        if (!Sys_RST_N) begin
            pre_q          <= 16'd0;
            idx_q          <= 3'd0;
            frm_q          <= 25'd0;
            blk_q          <= 1'b0;
            load_pending_q <= 1'b1;
            seg_q          <= 8'hFF;
            dig_q          <= 7'h7F;
            frame_done_q   <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            idx_q          <= idx_d;
            frm_q          <= frm_d;
            blk_q          <= blk_d;
            load_pending_q <= load_pending_d;
            seg_q          <= seg_d;
            dig_q          <= dig_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign Seg_Out    = seg_q;
    assign Dig_Sel    = dig_q;
    assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: table vectors, hand-written frame/reset sequences, and
// randomized input changes checked every cycle against a timeline model of the display.
module tb_bcd_seg_scan;

    localparam int S  = 4;
    localparam int FR = 7 * S;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [24:0] data = 25'd0;
    logic        blk_en = 1'b0;
    logic [7:0]  seg;
    logic [6:0]  dig;
    logic        fd;

    int n_vec = 0;
    int n_err = 0;
    int t = 0;
    logic [24:0] frq[$];
    logic        fbq[$];

    typedef struct {
        logic [24:0] d;
        logic        b;
        logic [55:0] s;
    } vec_t;
    vec_t vecs[6];

    bcd_seg_scan #(.SCAN_DIV(S)) dut (
        .Sys_CLK(clk), .Sys_RST_N(rst_n), .Data_BCD(data), .Blank_En(blk_en),
        .Seg_Out(seg), .Dig_Sel(dig), .Frame_Done(fd)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(int v);
        case (v)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    // What the display should show for digit i of a frame, from the display rules.
    function automatic logic [7:0] exp_seg(logic [24:0] d, logic b, int i);
        int v[7];
        bit all_zero;
        for (int j = 0; j < 6; j++) v[j] = int'((d >> (4 * j)) & 25'hF);
        v[6] = int'(d[24]);
        all_zero = 1'b1;
        for (int j = i; j <= 6; j++) if (v[j] != 0) all_zero = 1'b0;
        if (b && i > 0 && all_zero) return 8'hFF;
        return glyph(v[i]);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got %h expected %h", nm, t, act, exp);
        end
    endtask

    // Outputs after edge t: edge 1 loads frame 0; pins show scan position k=t-2 afterwards.
    task automatic model_check();
        int k, idx, f;
        logic [6:0] de;
        if (t == 1) begin
            chk("load_seg", 32'(seg), 32'h0FF);
            chk("load_dig", 32'(dig), 32'h07F);
            chk("load_fd", 32'(fd), 32'h0);
        end else begin
            k   = t - 2;
            idx = (k / S) % 7;
            f   = k / FR;
            de  = ~(7'b000_0001 << idx);
            if (f >= frq.size()) begin
                chk("model_frame", 32'(f), 32'(frq.size()));
            end else begin
                chk("seg", 32'(seg), 32'(exp_seg(frq[f], fbq[f], idx)));
            end
            chk("dig", 32'(dig), 32'(de));
            chk("frame_done", 32'(fd), 32'((t % FR) == 0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        if ((t - 1) % FR == 0) begin
            frq.push_back(data);
            fbq.push_back(blk_en);
        end
        @(negedge clk);
        model_check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h0FF);
        chk("rst_dig", 32'(dig), 32'h07F);
        chk("rst_fd", 32'(fd), 32'h0);
        rst_n = 1'b1;
        t = 0;
        frq.delete();
        fbq.delete();
    endtask

    function automatic logic [24:0] rand_bcd();
        logic [24:0] d;
        int r;
        d = 25'd0;
        for (int j = 0; j < 6; j++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3) d[4*j +: 4] = 4'd0;
            else if (r == 9) d[4*j +: 4] = 4'($urandom_range(10, 15));
            else d[4*j +: 4] = 4'($urandom_range(0, 9));
        end
        d[24] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) d[24:12] = 13'd0;
        return d;
    endfunction

    initial begin
        vecs[0] = '{25'h0000019, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'h90}};
        vecs[1] = '{25'h1048575, 1'b1, {8'hF9, 8'hC0, 8'h99, 8'h80, 8'h92, 8'hF8, 8'h92}};
        vecs[2] = '{25'h0000000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[3] = '{25'h0000000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vecs[4] = '{25'h0000C34, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hB0, 8'h99}};
        vecs[5] = '{25'h0043508, 1'b0, {8'hC0, 8'hC0, 8'h99, 8'hB0, 8'h92, 8'hC0, 8'h80}};

        for (int v = 0; v < 6; v++) begin
            data   = vecs[v].d;
            blk_en = vecs[v].b;
            do_reset();
            for (int c = 0; c < FR + 2; c++) begin
                tick();
                if (t >= 2 && ((t - 2) % S) == 1 && ((t - 2) / S) < 7) begin
                    chk("table_seg", 32'(seg), 32'(vecs[v].s[8 * ((t - 2) / S) +: 8]));
                end
            end
        end

        // Source changes while digit 3 is on the pins; old frame must finish first.
        data = 25'h0000019; blk_en = 1'b1;
        do_reset();
        while (t < 2 + 3 * S) tick();
        data = 25'h0043508;
        for (int c = 0; c < 2 * FR; c++) tick();

        // Blank_En flipped mid-frame is only seen at the next load.
        data = 25'h0000007; blk_en = 1'b0;
        do_reset();
        while (t < 2 + 2 * S) tick();
        blk_en = 1'b1;
        for (int c = 0; c < 2 * FR; c++) tick();

        // One-cycle reset while digit 4 is lit, then a clean reload.
        data = 25'h1234567; blk_en = 1'b1;
        do_reset();
        while (t < 2 + 4 * S + 1) tick();
        data = 25'h0000305;
        do_reset();
        for (int c = 0; c < 2 * FR; c++) tick();

        // Random frames with the source and blank enable wandering underneath.
        for (int r = 0; r < 6; r++) begin
            data   = rand_bcd();
            blk_en = 1'($urandom_range(0, 1));
            do_reset();
            for (int c = 0; c < 3 * FR; c++) begin
                tick();
                if ($urandom_range(0, 4) == 0) data = rand_bcd();
                if ($urandom_range(0, 9) == 0) blk_en = ~blk_en;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
